// File: rtl/lcd_timing_pkg.sv
// Default panel timing (800x480) and the line/frame length helper shared by
// the LCD timing generator.
package lcd_timing_pkg;

  localparam int DEF_H_ACTIVE = 800;
  localparam int DEF_H_FP     = 40;
  localparam int DEF_H_SYNC   = 128;
  localparam int DEF_H_BP     = 88;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 1;
  localparam int DEF_V_SYNC   = 3;
  localparam int DEF_V_BP     = 21;
  localparam int DEF_DATA_W   = 24;
  localparam int DEF_PIX_LAT  = 2;

  function automatic int calc_total(input int sync_len, input int bp_len,
                                    input int active_len, input int fp_len);
    return sync_len + bp_len + active_len + fp_len;
  endfunction

endpackage

// File: rtl/lcd_sync_delay.sv
// Reset-flushable shift register that carries the panel control flags so they
// line up with pixel data returned by the frame source.
module lcd_sync_delay #(
  parameter int             W       = 5,
  parameter int             DEPTH   = 3,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] dly_p [DEPTH];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) dly_p[i] <= RST_VAL;
    end else begin
      dly_p[0] <= din;
      for (int i = 1; i < DEPTH; i++) dly_p[i] <= dly_p[i-1];
    end
  end

  assign dout = dly_p[DEPTH-1];

endmodule

// File: rtl/lcd_timing_gen.sv
// LCD/RGB panel timing generator: raster counters, region decode, pixel request
// stage and a delay line that keeps hsync/vsync/de aligned with returned pixels.
module lcd_timing_gen
  import lcd_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int PIX_LAT  = DEF_PIX_LAT,
  localparam int H_TOTAL = calc_total(H_SYNC, H_BP, H_ACTIVE, H_FP),
  localparam int V_TOTAL = calc_total(V_SYNC, V_BP, V_ACTIVE, V_FP),
  localparam int XW      = $clog2(H_ACTIVE),
  localparam int YW      = $clog2(V_ACTIVE)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  output logic              pix_req_o,
  output logic [XW-1:0]     pix_x_o,
  output logic [YW-1:0]     pix_y_o,
  input  logic [DATA_W-1:0] pix_data_i,
  output logic              lcd_dclk,
  output logic              lcd_hsync,
  output logic              lcd_vsync,
  output logic              lcd_de,
  output logic [DATA_W-1:0] lcd_data,
  output logic              frame_start_o,
  output logic              line_start_o
);

  localparam int HCW = $clog2(H_TOTAL);
  localparam int VCW = $clog2(V_TOTAL);

  localparam logic [31:0] HS_END = 32'(H_SYNC);
  localparam logic [31:0] VS_END = 32'(V_SYNC);
  localparam logic [31:0] HA_S   = 32'(H_SYNC + H_BP);
  localparam logic [31:0] HA_E   = 32'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [31:0] VA_S   = 32'(V_SYNC + V_BP);
  localparam logic [31:0] VA_E   = 32'(V_SYNC + V_BP + V_ACTIVE);

  localparam logic [HCW-1:0] H_LAST = HCW'(H_TOTAL - 1);
  localparam logic [VCW-1:0] V_LAST = VCW'(V_TOTAL - 1);
  localparam logic [HCW-1:0] HA_S_C = HCW'(H_SYNC + H_BP);
  localparam logic [VCW-1:0] VA_S_C = VCW'(V_SYNC + V_BP);

  logic [HCW-1:0] h_p0;
  logic [VCW-1:0] v_p0;
  logic [31:0]    h_ext, v_ext;
  logic           hs_raw, vs_raw, de_raw, frame_raw, line_raw;

  logic           vld_p1, hs_p1, vs_p1, frame_p1, line_p1;
  logic [XW-1:0]  x_p1;
  logic [YW-1:0]  y_p1;
  logic [4:0]     flags_dly;
  logic [DATA_W-1:0] data_p2;

  // Stage 0: raster counters, parked at the frame origin while disabled
  always_ff @(posedge clk_i) begin
    if (rst_i || !en_i) begin
      h_p0 <= '0;
      v_p0 <= '0;
    end else if (h_p0 == H_LAST) begin
      h_p0 <= '0;
      v_p0 <= (v_p0 == V_LAST) ? '0 : v_p0 + 1'b1;
    end else begin
      h_p0 <= h_p0 + 1'b1;
    end
  end

  assign h_ext     = 32'(h_p0);
  assign v_ext     = 32'(v_p0);
  assign hs_raw    = en_i && (h_ext < HS_END);
  assign vs_raw    = en_i && (v_ext < VS_END);
  assign de_raw    = en_i && (h_ext >= HA_S) && (h_ext < HA_E)
                          && (v_ext >= VA_S) && (v_ext < VA_E);
  assign frame_raw = en_i && (h_p0 == '0) && (v_p0 == '0);
  assign line_raw  = en_i && (h_p0 == '0);

  // Stage 1: pixel request to the frame source
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_p1   <= 1'b0;
      hs_p1    <= ~HS_POL;
      vs_p1    <= ~VS_POL;
      frame_p1 <= 1'b0;
      line_p1  <= 1'b0;
    end else begin
      vld_p1   <= de_raw;
      hs_p1    <= hs_raw ? HS_POL : ~HS_POL;
      vs_p1    <= vs_raw ? VS_POL : ~VS_POL;
      frame_p1 <= frame_raw;
      line_p1  <= line_raw;
    end
  end

  always_ff @(posedge clk_i) begin
    x_p1 <= XW'(h_p0 - HA_S_C);
    y_p1 <= YW'(v_p0 - VA_S_C);
  end

  assign pix_req_o = vld_p1;
  assign pix_x_o   = vld_p1 ? x_p1 : '0;
  assign pix_y_o   = vld_p1 ? y_p1 : '0;

  // Stage 2..PIX_LAT+2: control flags wait for the source's read latency
  lcd_sync_delay #(
    .W       (5),
    .DEPTH   (PIX_LAT + 1),
    .RST_VAL ({~HS_POL, ~VS_POL, 3'b000})
  ) u_sync_delay (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .din   ({hs_p1, vs_p1, vld_p1, frame_p1, line_p1}),
    .dout  (flags_dly)
  );

  assign {lcd_hsync, lcd_vsync, lcd_de, frame_start_o, line_start_o} = flags_dly;

  always_ff @(posedge clk_i) begin
    data_p2 <= pix_data_i;
  end

  assign lcd_data = lcd_de ? data_p2 : '0;
  assign lcd_dclk = ~clk_i;

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Bench for lcd_timing_gen: three instances (PIX_LAT 2/0/15, both polarities)
// checked every cycle against a raster-position model plus literal timing checks.
module tb_lcd_timing_gen;

  localparam int HT = 15;
  localparam int VT = 8;
  localparam int FT = HT * VT;
  localparam int DW = 24;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic en  = 1'b0;

  logic [2:0]          req, hs, vs, de, fs, ls, dclk;
  logic [2:0][2:0]     px;
  logic [2:0][1:0]     py;
  logic [2:0][DW-1:0]  pdata, ldata;

  int checks   = 0;
  int failures = 0;

  lcd_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2), .V_ACTIVE(4), .V_FP(1),
    .V_SYNC(2), .V_BP(1), .HS_POL(1'b0), .VS_POL(1'b0), .DATA_W(DW), .PIX_LAT(2)) u0 (
    .clk_i(clk), .rst_i(rst), .en_i(en), .pix_req_o(req[0]), .pix_x_o(px[0]), .pix_y_o(py[0]),
    .pix_data_i(pdata[0]), .lcd_dclk(dclk[0]), .lcd_hsync(hs[0]), .lcd_vsync(vs[0]),
    .lcd_de(de[0]), .lcd_data(ldata[0]), .frame_start_o(fs[0]), .line_start_o(ls[0]));

  lcd_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2), .V_ACTIVE(4), .V_FP(1),
    .V_SYNC(2), .V_BP(1), .HS_POL(1'b1), .VS_POL(1'b1), .DATA_W(DW), .PIX_LAT(0)) u1 (
    .clk_i(clk), .rst_i(rst), .en_i(en), .pix_req_o(req[1]), .pix_x_o(px[1]), .pix_y_o(py[1]),
    .pix_data_i(pdata[1]), .lcd_dclk(dclk[1]), .lcd_hsync(hs[1]), .lcd_vsync(vs[1]),
    .lcd_de(de[1]), .lcd_data(ldata[1]), .frame_start_o(fs[1]), .line_start_o(ls[1]));

  lcd_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2), .V_ACTIVE(4), .V_FP(1),
    .V_SYNC(2), .V_BP(1), .HS_POL(1'b1), .VS_POL(1'b1), .DATA_W(DW), .PIX_LAT(15)) u2 (
    .clk_i(clk), .rst_i(rst), .en_i(en), .pix_req_o(req[2]), .pix_x_o(px[2]), .pix_y_o(py[2]),
    .pix_data_i(pdata[2]), .lcd_dclk(dclk[2]), .lcd_hsync(hs[2]), .lcd_vsync(vs[2]),
    .lcd_de(de[2]), .lcd_data(ldata[2]), .frame_start_o(fs[2]), .line_start_o(ls[2]));

  function automatic int lat(input int i);
    case (i)
      0:       return 2;
      1:       return 0;
      default: return 15;
    endcase
  endfunction

  function automatic bit pol(input int i);
    return (i != 0);
  endfunction

  task automatic chk(input string name, input int i, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] t=%0t got=%0h expected=%0h", name, i, $time, act, exp);
    end
  endtask

  // What the raster says at each clock edge: position -> flags and pixel
  typedef struct {
    bit          act;
    int          x;
    int          y;
    bit          hs;
    bit          vs;
    bit          fr;
    bit          ln;
    logic [18:0] tag;
  } ent_t;

  ent_t hist [32];
  bit   rsth [32];
  ent_t cur;
  int   k   = 0;
  int   pos = 0;
  int   mh, mv, m, j;
  bit   fl, ede, ehs, evs, efr, eln;
  logic [DW-1:0] edata;

  always begin
    @(posedge clk);
    mh = pos % HT;
    mv = pos / HT;
    cur.act = en && !rst && mh >= 5 && mh < 13 && mv >= 3 && mv < 7;
    cur.x   = cur.act ? mh - 5 : 0;
    cur.y   = cur.act ? mv - 3 : 0;
    cur.hs  = en && !rst && mh < 3;
    cur.vs  = en && !rst && mv < 2;
    cur.fr  = en && !rst && pos == 0;
    cur.ln  = en && !rst && mh == 0;
    cur.tag = 19'($urandom);
    hist[k % 32] = cur;
    rsth[k % 32] = rst;
    pos = (rst || !en) ? 0 : (pos + 1) % FT;
    #1;
    if (k >= 2) begin
      for (int i = 0; i < 3; i++) begin
        chk("pix_req", i, 32'(req[i]), 32'(hist[k % 32].act));
        chk("pix_x", i, 32'(px[i]), 32'(hist[k % 32].x));
        chk("pix_y", i, 32'(py[i]), 32'(hist[k % 32].y));
        m  = k - lat(i) - 1;
        fl = (m < 0);
        for (int q = m; q <= k; q++) if (q >= 0 && rsth[q % 32]) fl = 1'b1;
        ede = 1'b0; ehs = 1'b0; evs = 1'b0; efr = 1'b0; eln = 1'b0; edata = '0;
        if (!fl) begin
          ede = hist[m % 32].act;
          ehs = hist[m % 32].hs;
          evs = hist[m % 32].vs;
          efr = hist[m % 32].fr;
          eln = hist[m % 32].ln;
          if (ede) edata = {hist[m % 32].tag, 2'(hist[m % 32].y), 3'(hist[m % 32].x)};
        end
        chk("lcd_de", i, 32'(de[i]), 32'(ede));
        chk("lcd_hsync", i, 32'(hs[i]), 32'(ehs ? pol(i) : !pol(i)));
        chk("lcd_vsync", i, 32'(vs[i]), 32'(evs ? pol(i) : !pol(i)));
        chk("frame_start", i, 32'(fs[i]), 32'(efr));
        chk("line_start", i, 32'(ls[i]), 32'(eln));
        chk("lcd_data", i, 32'(ldata[i]), 32'(edata));
      end
    end
    for (int i = 0; i < 3; i++) begin
      j = k - lat(i);
      if (j >= 0 && hist[j % 32].act)
        pdata[i] = {hist[j % 32].tag, 2'(hist[j % 32].y), 3'(hist[j % 32].x)};
      else
        pdata[i] = DW'($urandom);
    end
    k++;
  end

  int first_req [3];
  int first_de  [3];
  int last_ls, ffs, n;
  int c_hs, c_vs, c_de, c_fs, c_hs1, c_dd;

  task automatic wait_pos(input int target, input string name);
    int w;
    w = 0;
    while (pos != target && w < 400) begin
      @(negedge clk);
      w++;
    end
    chk(name, 0, 32'(pos), 32'(target));
  endtask

  initial begin
    for (int i = 0; i < 3; i++) pdata[i] = '0;
    repeat (5) @(negedge clk);

    // Free run from reset release: latency and per-frame counts
    rst = 1'b0;
    en  = 1'b1;
    for (int i = 0; i < 3; i++) begin first_req[i] = -1; first_de[i] = -1; end
    last_ls = -1; ffs = -1;
    c_hs = 0; c_vs = 0; c_de = 0; c_fs = 0; c_hs1 = 0;
    for (n = 1; n <= 300; n++) begin
      @(negedge clk);
      if (first_de[0] < 0 && ls[0]) last_ls = n;
      for (int i = 0; i < 3; i++) begin
        if (first_req[i] < 0 && req[i]) first_req[i] = n;
        if (first_de[i] < 0 && de[i]) first_de[i] = n;
      end
      if (ffs < 0 && fs[0]) ffs = n;
      if (n >= 31 && n <= 270) begin
        c_hs  += int'(!hs[0]);
        c_vs  += int'(!vs[0]);
        c_de  += int'(de[0]);
        c_fs  += int'(fs[0]);
        c_hs1 += int'(hs[1]);
      end
    end
    for (int i = 0; i < 3; i++) chk("first_req_cycle", i, 32'(first_req[i]), 32'd51);
    chk("first_de_cycle", 0, 32'(first_de[0]), 32'd54);
    chk("first_de_cycle", 1, 32'(first_de[1]), 32'd52);
    chk("first_de_cycle", 2, 32'(first_de[2]), 32'd67);
    chk("line_to_de", 0, 32'(first_de[0] - last_ls), 32'd5);
    chk("frame_after_release", 0, 32'(ffs), 32'd4);
    chk("hsync_low_2frames", 0, 32'(c_hs), 32'd48);
    chk("vsync_low_2frames", 0, 32'(c_vs), 32'd60);
    chk("de_high_2frames", 0, 32'(c_de), 32'd64);
    chk("frame_pulses_2frames", 0, 32'(c_fs), 32'd2);
    chk("hsync_high_inverted", 1, 32'(c_hs1), 32'd48);

    // Mid-frame reset at h=9, v=4
    wait_pos(4 * HT + 9, "wait_rst_point");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("rst_req", i, 32'(req[i]), 32'd0);
      chk("rst_xy", i, 32'({px[i], py[i]}), 32'd0);
      chk("rst_de", i, 32'(de[i]), 32'd0);
      chk("rst_data", i, 32'(ldata[i]), 32'd0);
      chk("rst_pulses", i, 32'({fs[i], ls[i]}), 32'd0);
      chk("rst_hsync", i, 32'(hs[i]), 32'(!pol(i)));
      chk("rst_vsync", i, 32'(vs[i]), 32'(!pol(i)));
    end
    ffs = -1; c_dd = 0;
    for (n = 1; n <= 50; n++) begin
      @(negedge clk);
      if (ffs < 0 && fs[0]) ffs = n;
      c_dd += int'(de[0]);
    end
    chk("frame_after_rst", 0, 32'(ffs), 32'd4);
    chk("stale_de_after_rst", 0, 32'(c_dd), 32'd0);

    // Enable dropped at h=6, v=3 for 20 cycles
    wait_pos(3 * HT + 6, "wait_en_point");
    en = 1'b0;
    c_dd = 0;
    for (n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (n >= 4) c_dd += int'(de[0]);
    end
    chk("de_drained", 0, 32'(c_dd), 32'd0);
    en = 1'b1;
    c_de = 0; c_fs = 0; ffs = -1;
    for (n = 1; n <= 120; n++) begin
      @(negedge clk);
      c_de += int'(de[0]);
      c_fs += int'(fs[0]);
      if (ffs < 0 && fs[0]) ffs = n;
    end
    chk("restart_frame_de", 0, 32'(c_de), 32'd32);
    chk("restart_frame_pulses", 0, 32'(c_fs), 32'd1);
    chk("frame_after_enable", 0, 32'(ffs), 32'd4);

    // Random reset pulses and enable toggles
    for (n = 0; n < 800; n++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 59) == 0) en = ~en;
    end
    rst = 1'b0;
    en  = 1'b1;
    repeat (40) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
